// File: rtl/adder_seq_pkg.sv
// -----------------------------------------------------------------------------
// adder_seq_pkg
// Shared definitions for the multi-precision add sequencer:
//   CHUNK_W   - width of one chunk handled by the shared adder
//   MAX_WORDS - largest supported number of chunks
//   K_W       - width of the chunk index register
//   state_t   - sequencer FSM states
//   ovf_calc  - two's-complement overflow from the top bits of a, b and sum
// -----------------------------------------------------------------------------
package adder_seq_pkg;

    localparam int CHUNK_W   = 6;
    localparam int MAX_WORDS = 16;
    localparam int K_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        INC  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic ovf_calc(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_new.sv
// -----------------------------------------------------------------------------
// adder_new
// 6-bit Kogge-Stone style parallel-prefix adder, purely combinational,
// without carry-in.
//   X, Y : 6-bit addends
//   S    : 6-bit sum
//   cout : carry out of bit 5
// -----------------------------------------------------------------------------
module adder_new (
    input  logic [5:0] X,
    input  logic [5:0] Y,
    output logic [5:0] S,
    output logic       cout
);

    logic [5:0] g0_s;
    logic [5:0] p0_s;
    logic [5:0] g1_s;
    logic [5:0] p1_s;
    logic [5:0] g2_s;
    logic [5:0] p2_s;
    logic [5:0] g3_s;

    // Prefix tree: spans of 1, 2 and 4 bits; g3_s[i] is the carry out of bit i.
    always_comb begin
        g0_s = X & Y;
        p0_s = X ^ Y;

        g1_s[0] = g0_s[0];
        p1_s[0] = p0_s[0];
        for (int i = 1; i < 6; i++) begin
            g1_s[i] = g0_s[i] | (p0_s[i] & g0_s[i-1]);
            p1_s[i] = p0_s[i] & p0_s[i-1];
        end

        g2_s[1:0] = g1_s[1:0];
        p2_s[1:0] = p1_s[1:0];
        for (int i = 2; i < 6; i++) begin
            g2_s[i] = g1_s[i] | (p1_s[i] & g1_s[i-2]);
            p2_s[i] = p1_s[i] & p1_s[i-2];
        end

        g3_s[3:0] = g2_s[3:0];
        for (int i = 4; i < 6; i++) begin
            g3_s[i] = g2_s[i] | (p2_s[i] & g2_s[i-4]);
        end

        S    = p0_s ^ {g3_s[4:0], 1'b0};
        cout = g3_s[5];
    end

endmodule

// File: rtl/adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adder_seq_ctrl
// Adds two 6*WORDS-bit operands plus a carry-in, one 6-bit chunk per cycle,
// LSB first, using a single shared adder_new instance. The shared adder has
// no carry-in, so a chunk entered with carry 1 takes a second pass (sum + 1).
//
// Parameters:
//   WORDS     - number of 6-bit chunks (1..16)
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - operand handshake (in_ready high only in IDLE)
//   a, b, cin           - operands and initial carry, sampled on accept
//   out_valid/out_ready - result handshake, result held until consumed
//   sum, cout           - registered result and carry out of the top chunk
//   busy                - high while adding (ADD or INC)
//   ovf                 - signed overflow, present only when ADDSEQ_OVF_EN
//                         is defined
// -----------------------------------------------------------------------------
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHUNK_W*WORDS-1:0]   a,
    input  logic [CHUNK_W*WORDS-1:0]   b,
    input  logic                       cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHUNK_W*WORDS-1:0]   sum,
    output logic                       cout,
    output logic                       busy
`ifdef ADDSEQ_OVF_EN
    ,
    output logic                       ovf
`endif
);

    localparam int             W      = CHUNK_W * WORDS;
    localparam logic [K_W-1:0] LAST_K = K_W'(WORDS - 1);

    state_t                 state_r;
    logic [W-1:0]           a_r;
    logic [W-1:0]           b_r;
    logic [W-1:0]           sum_r;
    logic [K_W-1:0]         k_r;
    logic                   c_r;
    logic                   c1_r;
    logic                   cout_r;
    logic                   out_valid_r;
    logic                   busy_r;
`ifdef ADDSEQ_OVF_EN
    logic                   ovf_r;
`endif

    logic [CHUNK_W-1:0]     x_s;
    logic [CHUNK_W-1:0]     y_s;
    logic [CHUNK_W-1:0]     s_s;
    logic                   co_s;
    logic                   last_s;

    assign last_s = (k_r == LAST_K);

    // Adder operand mux: chunk add in ADD, +1 carry injection in INC.
    always_comb begin
        case (state_r)
            ADD: begin
                x_s = a_r[k_r*CHUNK_W +: CHUNK_W];
                y_s = b_r[k_r*CHUNK_W +: CHUNK_W];
            end
            INC: begin
                x_s = sum_r[k_r*CHUNK_W +: CHUNK_W];
                y_s = 6'd1;
            end
            default: begin
                x_s = 6'd0;
                y_s = 6'd0;
            end
        endcase
    end

    adder_new u_adder (
        .X    (x_s),
        .Y    (y_s),
        .S    (s_s),
        .cout (co_s)
    );

    // Sequencer FSM with operand, result and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            k_r         <= '0;
            c_r         <= 1'b0;
            c1_r        <= 1'b0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef ADDSEQ_OVF_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        c_r     <= cin;
                        k_r     <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ADD;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                ADD: begin
                    sum_r[k_r*CHUNK_W +: CHUNK_W] <= s_s;
                    if (c_r) begin
                        // Pending carry: keep this pass's carry for the +1 pass.
                        c1_r    <= co_s;
                        state_r <= INC;
                    end else begin
                        c_r <= co_s;
                        if (last_s) begin
                            cout_r      <= co_s;
                            out_valid_r <= 1'b1;
                            busy_r      <= 1'b0;
`ifdef ADDSEQ_OVF_EN
                            ovf_r       <= ovf_calc(a_r[W-1], b_r[W-1], s_s[CHUNK_W-1]);
`endif
                            state_r     <= DONE;
                        end else begin
                            k_r     <= k_r + 4'd1;
                            state_r <= ADD;
                        end
                    end
                end

                INC: begin
                    sum_r[k_r*CHUNK_W +: CHUNK_W] <= s_s;
                    // Both passes of one chunk never carry together, so OR is exact.
                    c_r <= c1_r | co_s;
                    if (last_s) begin
                        cout_r      <= c1_r | co_s;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
`ifdef ADDSEQ_OVF_EN
                        ovf_r       <= ovf_calc(a_r[W-1], b_r[W-1], s_s[CHUNK_W-1]);
`endif
                        state_r     <= DONE;
                    end else begin
                        k_r     <= k_r + 4'd1;
                        state_r <= ADD;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end

                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
`ifdef ADDSEQ_OVF_EN
    assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_seq_ctrl
// Directed vector table plus random operands against a reference model,
// backpressure and mid-operation reset sequences. WORDS = 4 (24-bit operands).
// Overflow checks are compiled in when ADDSEQ_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_adder_seq_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 6 * WORDS;
    localparam int TMO   = 40;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef ADDSEQ_OVF_EN
    logic         ovf;
`endif

    int checks;
    int failures;

    adder_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef ADDSEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present operands for one accept edge; returns #1 after that edge.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < TMO) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (out_valid !== 1'b1) chk("timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("in_ready_after_consume", 32'(in_ready), 32'd1);
        chk("out_valid_after_consume", 32'(out_valid), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        start_op(v.a, v.b, v.cin);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_result(lat);
        chk({tag, "_sum"}, 32'(sum), 32'(v.sum));
        chk({tag, "_cout"}, 32'(cout), 32'(v.cout));
        chk({tag, "_lat"}, 32'(lat), 32'(v.lat));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
`ifdef ADDSEQ_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(v.ovf));
`endif
        consume();
    endtask

    vec_t vecs[8];

    initial begin
        vec_t         v;
        int           lat;
        logic [W:0]   full;
        logic [W-1:0] hold_sum;
        logic         hold_cout;
        int           kk;
        logic         cc;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        //           a            b            cin   sum          cout  ovf   lat
        vecs[0] = '{24'h000001, 24'h000002, 1'b0, 24'h000003, 1'b0, 1'b0, 4};
        vecs[1] = '{24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, 1'b0, 7};
        vecs[2] = '{24'h000000, 24'h000000, 1'b1, 24'h000001, 1'b0, 1'b0, 5};
        vecs[3] = '{24'h00003F, 24'h000001, 1'b0, 24'h000040, 1'b0, 1'b0, 5};
        vecs[4] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 1'b1, 1'b0, 8};
        vecs[5] = '{24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b1, 1'b1, 4};
        vecs[6] = '{24'h123456, 24'h654321, 1'b0, 24'h777777, 1'b0, 1'b0, 4};
        vecs[7] = '{24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 1'b0, 1'b1, 7};

        // Reset state
        #2;
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ADDSEQ_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Random operands against an arithmetic reference model
        for (int n = 0; n < 200; n++) begin
            v.a   = W'($urandom);
            v.b   = W'($urandom);
            v.cin = 1'($urandom_range(0, 1));
            full  = {1'b0, v.a} + {1'b0, v.b} + {{W{1'b0}}, v.cin};
            v.sum  = full[W-1:0];
            v.cout = full[W];
            v.ovf  = (v.a[W-1] == v.b[W-1]) && (full[W-1] != v.a[W-1]);
            kk = 0;
            cc = v.cin;
            for (int j = 0; j < WORDS; j++) begin
                logic [6:0] part;
                if (cc) kk++;
                part = {1'b0, v.a[j*6 +: 6]} + {1'b0, v.b[j*6 +: 6]} + {6'd0, cc};
                cc = part[6];
            end
            v.lat = WORDS + kk;
            run_vec(v, $sformatf("rand%0d", n));
        end

        // Backpressure: result frozen, new operands ignored, then back-to-back accept
        start_op(24'h0000FF, 24'h000001, 1'b0);
        wait_result(lat);
        chk("bp_sum", 32'(sum), 32'h000100);
        hold_sum  = sum;
        hold_cout = cout;
        a        = 24'h000010;
        b        = 24'h000020;
        cin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_sum", 32'(sum), 32'(hold_sum));
            chk("bp_hold_cout", 32'(cout), 32'(hold_cout));
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_accept_busy", 32'(busy), 32'd1);
        chk("b2b_accept_in_ready", 32'(in_ready), 32'd0);
        wait_result(lat);
        chk("b2b_sum", 32'(sum), 32'h000030);
        chk("b2b_cout", 32'(cout), 32'd0);
        chk("b2b_lat", 32'(lat), 32'd4);
        consume();

        // Reset while the +1 pass of chunk 2 is in flight
        start_op(24'hFFFFFF, 24'h000001, 1'b0);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle_valid", 32'(out_valid), 32'd0);
        start_op(24'h00003F, 24'h000001, 1'b0);
        wait_result(lat);
        chk("post_rst_sum", 32'(sum), 32'h000040);
        chk("post_rst_cout", 32'(cout), 32'd0);
        chk("post_rst_lat", 32'(lat), 32'd5);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
